// File: rtl/shift_operand_sequencer_pkg.sv
// Shared definitions for the operand-2 shift sequencer: word width, FSM states,
// request mode codes and barrel-shifter type codes.
`ifndef WordWidth
`define WordWidth 32
`endif

package shift_operand_sequencer_pkg;

  localparam int WORD_WIDTH = `WordWidth;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_READ_RS = 2'd1,
    ST_SHIFT   = 2'd2,
    ST_HOLD    = 2'd3
  } seq_state_t;

  typedef enum logic [1:0] {
    MODE_IMM_ROT   = 2'b00,
    MODE_IMM_SHIFT = 2'b01,
    MODE_REG_SHIFT = 2'b10,
    MODE_RSVD      = 2'b11
  } op_mode_t;

  localparam logic [1:0] SHIFT_LSL = 2'b00;
  localparam logic [1:0] SHIFT_LSR = 2'b01;
  localparam logic [1:0] SHIFT_ASR = 2'b10;
  localparam logic [1:0] SHIFT_ROR = 2'b11;

endpackage

// File: rtl/shift_operand_sequencer_barrel_shifter.sv
// 32-bit barrel shifter using the immediate-shift encoding: amount 0 means
// LSL#0 (pass), LSR#32, ASR#32 or RRX depending on the shift type.
module shift_operand_sequencer_barrel_shifter
  import shift_operand_sequencer_pkg::*;
(
  input  logic [WORD_WIDTH-1:0] val,
  input  logic [1:0]            shift_type,
  input  logic [4:0]            amt,
  input  logic                  c_in,
  output logic [WORD_WIDTH-1:0] result,
  output logic                  carry_out
);

  localparam logic [5:0] WORD_BITS = 6'(WORD_WIDTH);

  logic [WORD_WIDTH:0]        lsl_w;
  logic [WORD_WIDTH:0]        lsr_w;
  logic signed [WORD_WIDTH:0] asr_w;
  logic [WORD_WIDTH-1:0]      ror_w;

  // Extra bit on each side catches the last bit shifted out as the carry.
  assign lsl_w = {1'b0, val} << amt;
  assign lsr_w = {val, 1'b0} >> amt;
  assign asr_w = $signed({val, 1'b0}) >>> amt;
  assign ror_w = (val >> amt) | (val << (WORD_BITS - {1'b0, amt}));

  always_comb begin
    result    = val;
    carry_out = c_in;
    case (shift_type)
      SHIFT_LSL: begin
        if (amt != 5'd0) begin
          result    = lsl_w[WORD_WIDTH-1:0];
          carry_out = lsl_w[WORD_WIDTH];
        end
      end
      SHIFT_LSR: begin
        if (amt == 5'd0) begin
          result    = '0;
          carry_out = val[WORD_WIDTH-1];
        end else begin
          result    = lsr_w[WORD_WIDTH:1];
          carry_out = lsr_w[0];
        end
      end
      SHIFT_ASR: begin
        if (amt == 5'd0) begin
          result    = {WORD_WIDTH{val[WORD_WIDTH-1]}};
          carry_out = val[WORD_WIDTH-1];
        end else begin
          result    = asr_w[WORD_WIDTH:1];
          carry_out = asr_w[0];
        end
      end
      default: begin
        if (amt == 5'd0) begin
          result    = {c_in, val[WORD_WIDTH-1:1]};
          carry_out = val[0];
        end else begin
          result    = ror_w;
          carry_out = ror_w[WORD_WIDTH-1];
        end
      end
    endcase
  end

endmodule

// File: rtl/shift_operand_sequencer.sv
// Operand-2 front end: captures a request, fetches Rs when needed, runs the shifter
// and holds op2/carry for the ALU. Optional macro: SHIFT_RS_FORWARD_EN (Rs forwarding).
//
// state    | meaning
// ---------+---------------------------------------------------------
// IDLE     | ready for a request, captures inputs on in_Req_Valid
// READ_RS  | register-file read of Rs outstanding, waits for grant
// SHIFT    | shifter evaluated, result registered this cycle
// HOLD     | result presented, waits for in_Ready
module shift_operand_sequencer
  import shift_operand_sequencer_pkg::*;
#(
  parameter int REG_ADDR_WIDTH = 4,
  parameter int AMT_WIDTH      = 8
) (
  input  logic                      in_Clk,
  input  logic                      in_Rst_N,
  input  logic                      in_Req_Valid,
  output logic                      out_Req_Ready,
  input  logic [1:0]                in_Mode,
  input  logic [`WordWidth-1:0]     in_Val,
  input  logic [1:0]                in_Shift_type,
  input  logic [4:0]                in_Shift_imm,
  input  logic [REG_ADDR_WIDTH-1:0] in_Rs_Addr,
  input  logic                      in_C_flag,
  output logic                      out_Rs_Req,
  output logic [REG_ADDR_WIDTH-1:0] out_Rs_Addr,
  input  logic                      in_Rs_Gnt,
  input  logic [AMT_WIDTH-1:0]      in_Rs_Data,
`ifdef SHIFT_RS_FORWARD_EN
  input  logic                      in_Rs_Fwd_Valid,
  input  logic [AMT_WIDTH-1:0]      in_Rs_Fwd_Data,
`endif
  output logic                      out_Valid,
  input  logic                      in_Ready,
  output logic [`WordWidth-1:0]     out_Op2,
  output logic                      out_Carry
);

  seq_state_t state_q, state_d;

  op_mode_t              mode_norm, mode_q;
  logic [WORD_WIDTH-1:0] val_q;
  logic [1:0]            type_q;
  logic [4:0]            imm_q;
  logic                  c_q;
  logic [AMT_WIDTH-1:0]  amt_q;

  logic accept, rs_take, load_result, clear_valid;
  logic fwd_hit;
  logic [AMT_WIDTH-1:0] fwd_data;

  logic [1:0]            sh_type;
  logic [4:0]            sh_amt;
  logic [WORD_WIDTH-1:0] sh_result;
  logic                  sh_carry;
  logic                  ovr_en;
  logic [WORD_WIDTH-1:0] ovr_op2;
  logic                  ovr_carry;
  logic [WORD_WIDTH-1:0] op2_d;
  logic                  carry_d;

`ifdef SHIFT_RS_FORWARD_EN
  assign fwd_hit  = in_Rs_Fwd_Valid;
  assign fwd_data = in_Rs_Fwd_Data;
`else
  assign fwd_hit  = 1'b0;
  assign fwd_data = '0;
`endif

  // Reserved mode 11 behaves exactly like an immediate shift.
  assign mode_norm = (in_Mode == MODE_RSVD) ? MODE_IMM_SHIFT : op_mode_t'(in_Mode);

  always_ff @(posedge in_Clk or negedge in_Rst_N) begin
    if (!in_Rst_N) state_q <= ST_IDLE;
    else           state_q <= state_d;
  end

  always_comb begin
    state_d       = state_q;
    out_Req_Ready = 1'b0;
    out_Rs_Req    = 1'b0;
    accept        = 1'b0;
    rs_take       = 1'b0;
    load_result   = 1'b0;
    clear_valid   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        out_Req_Ready = 1'b1;
        if (in_Req_Valid) begin
          accept  = 1'b1;
          state_d = (mode_norm == MODE_REG_SHIFT && !fwd_hit) ? ST_READ_RS : ST_SHIFT;
        end
      end
      ST_READ_RS: begin
        out_Rs_Req = 1'b1;
        if (in_Rs_Gnt) begin
          rs_take = 1'b1;
          state_d = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        load_result = 1'b1;
        state_d     = ST_HOLD;
      end
      ST_HOLD: begin
        if (in_Ready) begin
          clear_valid = 1'b1;
          state_d     = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge in_Clk or negedge in_Rst_N) begin
    if (!in_Rst_N) begin
      mode_q      <= MODE_IMM_SHIFT;
      val_q       <= '0;
      type_q      <= '0;
      imm_q       <= '0;
      c_q         <= 1'b0;
      amt_q       <= '0;
      out_Rs_Addr <= '0;
      out_Op2     <= '0;
      out_Carry   <= 1'b0;
      out_Valid   <= 1'b0;
    end else begin
      if (accept) begin
        mode_q      <= mode_norm;
        val_q       <= in_Val;
        type_q      <= in_Shift_type;
        imm_q       <= in_Shift_imm;
        c_q         <= in_C_flag;
        out_Rs_Addr <= in_Rs_Addr;
        if (fwd_hit) amt_q <= fwd_data;
      end
      if (rs_take) amt_q <= in_Rs_Data;
      if (load_result) begin
        out_Op2   <= op2_d;
        out_Carry <= carry_d;
        out_Valid <= 1'b1;
      end
      if (clear_valid) out_Valid <= 1'b0;
    end
  end

  // Map the request onto the shifter's 5-bit encoding; cases it cannot express are overridden.
  always_comb begin
    sh_type   = type_q;
    sh_amt    = imm_q;
    ovr_en    = 1'b0;
    ovr_op2   = val_q;
    ovr_carry = c_q;
    case (mode_q)
      MODE_IMM_ROT: begin
        sh_type = SHIFT_ROR;
        sh_amt  = {imm_q[3:0], 1'b0};
        if (imm_q[3:0] == 4'd0) ovr_en = 1'b1;
      end
      MODE_REG_SHIFT: begin
        sh_amt = amt_q[4:0];
        if (amt_q == '0) begin
          ovr_en = 1'b1;
        end else begin
          case (type_q)
            SHIFT_LSL: begin
              if (amt_q > AMT_WIDTH'(31)) begin
                ovr_en    = 1'b1;
                ovr_op2   = '0;
                ovr_carry = (amt_q == AMT_WIDTH'(32)) ? val_q[0] : 1'b0;
              end
            end
            SHIFT_LSR: begin
              if (amt_q > AMT_WIDTH'(31)) begin
                ovr_en    = 1'b1;
                ovr_op2   = '0;
                ovr_carry = (amt_q == AMT_WIDTH'(32)) ? val_q[WORD_WIDTH-1] : 1'b0;
              end
            end
            SHIFT_ASR: begin
              if (amt_q > AMT_WIDTH'(31)) begin
                ovr_en    = 1'b1;
                ovr_op2   = {WORD_WIDTH{val_q[WORD_WIDTH-1]}};
                ovr_carry = val_q[WORD_WIDTH-1];
              end
            end
            default: begin
              if (amt_q[4:0] == 5'd0) begin
                ovr_en    = 1'b1;
                ovr_carry = val_q[WORD_WIDTH-1];
              end
            end
          endcase
        end
      end
      default: ;
    endcase
    op2_d   = ovr_en ? ovr_op2   : sh_result;
    carry_d = ovr_en ? ovr_carry : sh_carry;
  end

  shift_operand_sequencer_barrel_shifter u_shifter (
    .val        (val_q),
    .shift_type (sh_type),
    .amt        (sh_amt),
    .c_in       (c_q),
    .result     (sh_result),
    .carry_out  (sh_carry)
  );

endmodule

// File: tb/tb_shift_operand_sequencer.sv
// Randomized self-checking bench for shift_operand_sequencer against a bit-serial
// shift reference model. Optional macro: SHIFT_RS_FORWARD_EN (adds forwarding test).
module tb_shift_operand_sequencer;

  localparam logic [1:0] T_LSL = 2'd0;
  localparam logic [1:0] T_LSR = 2'd1;
  localparam logic [1:0] T_ASR = 2'd2;
  localparam logic [1:0] T_ROR = 2'd3;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [1:0]  mode = '0;
  logic [31:0] val = '0;
  logic [1:0]  typ = '0;
  logic [4:0]  imm = '0;
  logic [3:0]  rs_addr_in = '0;
  logic        c_flag = 1'b0;
  logic        rs_req;
  logic [3:0]  rs_addr_out;
  logic        rs_gnt = 1'b0;
  logic [7:0]  rs_data = '0;
  logic        valid;
  logic        ready = 1'b0;
  logic [31:0] op2;
  logic        carry;
`ifdef SHIFT_RS_FORWARD_EN
  logic        fwd_valid = 1'b0;
  logic [7:0]  fwd_data = '0;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  shift_operand_sequencer #(.REG_ADDR_WIDTH(4), .AMT_WIDTH(8)) dut (
    .in_Clk          (clk),
    .in_Rst_N        (rst_n),
    .in_Req_Valid    (req_valid),
    .out_Req_Ready   (req_ready),
    .in_Mode         (mode),
    .in_Val          (val),
    .in_Shift_type   (typ),
    .in_Shift_imm    (imm),
    .in_Rs_Addr      (rs_addr_in),
    .in_C_flag       (c_flag),
    .out_Rs_Req      (rs_req),
    .out_Rs_Addr     (rs_addr_out),
    .in_Rs_Gnt       (rs_gnt),
    .in_Rs_Data      (rs_data),
`ifdef SHIFT_RS_FORWARD_EN
    .in_Rs_Fwd_Valid (fwd_valid),
    .in_Rs_Fwd_Data  (fwd_data),
`endif
    .out_Valid       (valid),
    .in_Ready        (ready),
    .out_Op2         (op2),
    .out_Carry       (carry)
  );

  // Architectural shift by n positions, one bit at a time; returns {carry, result}.
  function automatic logic [32:0] shift_by(input logic [1:0] t, input logic [31:0] v,
                                           input int n, input logic c);
    logic [31:0] r;
    logic        co;
    r  = v;
    co = c;
    for (int i = 0; i < n; i++) begin
      case (t)
        T_LSL:   begin co = r[31]; r = {r[30:0], 1'b0}; end
        T_LSR:   begin co = r[0];  r = {1'b0, r[31:1]}; end
        T_ASR:   begin co = r[0];  r = {r[31], r[31:1]}; end
        default: begin co = r[0];  r = {r[0], r[31:1]}; end
      endcase
    end
    return {co, r};
  endfunction

  function automatic logic [32:0] model(input logic [1:0] m, input logic [31:0] v,
                                        input logic [1:0] t, input logic [4:0] im,
                                        input logic [7:0] rs, input logic c);
    int n;
    if (m == 2'b00) return shift_by(T_ROR, v, 2 * int'(im[3:0]), c);
    if (m == 2'b10) return shift_by(t, v, int'(rs), c);
    n = int'(im);
    if (im == 5'd0) begin
      if (t == T_LSR || t == T_ASR) n = 32;
      if (t == T_ROR) return {v[0], c, v[31:1]};
    end
    return shift_by(t, v, n, c);
  endfunction

  task automatic run_op(input logic [1:0] m, input logic [31:0] v, input logic [1:0] t,
                        input logic [4:0] im, input logic [3:0] ra, input logic [7:0] rd,
                        input logic c, input int wait_n, input bit fwd, input int hold_n,
                        output logic [31:0] o_op2, output logic o_carry, output int lat,
                        output int req_cnt, output bit addr_ok, output bit stable_ok,
                        output bit end_ok);
    @(posedge clk); #1;
    mode = m; val = v; typ = t; imm = im; rs_addr_in = ra; c_flag = c; req_valid = 1'b1;
`ifdef SHIFT_RS_FORWARD_EN
    fwd_valid = fwd; fwd_data = rd;
`endif
    @(posedge clk); #1;
    // Scramble every request input after accept; the captured copy must be used.
    req_valid = 1'b0; c_flag = ~c; val = $urandom; typ = 2'($urandom);
    imm = 5'($urandom); rs_addr_in = 4'($urandom); mode = 2'($urandom);
`ifdef SHIFT_RS_FORWARD_EN
    fwd_valid = 1'b0; fwd_data = 8'($urandom);
`endif
    req_cnt = 0;
    addr_ok = 1'b1;
    if (m == 2'b10 && !fwd) begin
      for (int i = 1; i <= wait_n; i++) begin
        if (rs_req) req_cnt++;
        if (rs_addr_out !== ra) addr_ok = 1'b0;
        if (i == wait_n) begin rs_gnt = 1'b1; rs_data = rd; end
        @(posedge clk); #1;
        rs_gnt = 1'b0; rs_data = 8'($urandom);
      end
    end
    if (rs_req) req_cnt++;
    lat = -1;
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk); #1;
      if (valid) begin lat = i; break; end
    end
    o_op2 = op2;
    o_carry = carry;
    stable_ok = 1'b1;
    for (int i = 0; i < hold_n; i++) begin
      @(posedge clk); #1;
      if (!valid || op2 !== o_op2 || carry !== o_carry || req_ready !== 1'b0) stable_ok = 1'b0;
    end
    ready = 1'b1;
    @(posedge clk); #1;
    ready = 1'b0;
    end_ok = (valid === 1'b0 && req_ready === 1'b1);
  endtask

  task automatic test_reset();
    checks++;
    if ({valid, rs_req, op2, carry, rs_addr_out, req_ready} !== {1'b0, 1'b0, 32'h0, 1'b0, 4'h0, 1'b1}) begin
      errors++;
      $display("FAIL reset valid=%b rs_req=%b op2=%h carry=%b addr=%h ready=%b exp 0 0 0 0 0 1",
               valid, rs_req, op2, carry, rs_addr_out, req_ready);
    end
  endtask

  task automatic test_imm_rotate();
    logic [31:0] o; logic oc; int lat, rc; bit aok, sok, eok;
    run_op(2'b00, 32'h0000_00FF, T_LSL, 5'd4, 4'h0, 8'h0, 1'b0, 1, 1'b0, 2, o, oc, lat, rc, aok, sok, eok);
    checks++;
    if ({oc, o} !== {1'b1, 32'hFF00_0000}) begin
      errors++; $display("FAIL imm_rot4 got %b/%h exp 1/ff000000", oc, o);
    end
    checks++;
    if (lat !== 1) begin errors++; $display("FAIL imm_rot_latency got %0d exp 1", lat); end
    checks++;
    if (!sok || !eok) begin errors++; $display("FAIL imm_rot_hold stable=%b end=%b exp 1 1", sok, eok); end
    run_op(2'b00, 32'h8000_0001, T_ROR, 5'd0, 4'h0, 8'h0, 1'b1, 1, 1'b0, 0, o, oc, lat, rc, aok, sok, eok);
    checks++;
    if ({oc, o} !== {1'b1, 32'h8000_0001}) begin
      errors++; $display("FAIL imm_rot0 got %b/%h exp 1/80000001", oc, o);
    end
  endtask

  task automatic test_imm_shift_zero();
    logic [31:0] o; logic oc; int lat, rc; bit aok, sok, eok;
    run_op(2'b01, 32'h8000_0000, T_LSR, 5'd0, 4'h0, 8'h0, 1'b0, 1, 1'b0, 0, o, oc, lat, rc, aok, sok, eok);
    checks++;
    if ({oc, o} !== {1'b1, 32'h0}) begin errors++; $display("FAIL imm_lsr32 got %b/%h exp 1/0", oc, o); end
    run_op(2'b11, 32'h0000_0003, T_ROR, 5'd0, 4'h0, 8'h0, 1'b1, 1, 1'b0, 0, o, oc, lat, rc, aok, sok, eok);
    checks++;
    if ({oc, o} !== {1'b1, 32'h8000_0001}) begin errors++; $display("FAIL imm_rrx got %b/%h exp 1/80000001", oc, o); end
    checks++;
    if (rc !== 0) begin errors++; $display("FAIL imm_no_rs_req got %0d exp 0", rc); end
  endtask

  task automatic test_reg_shift();
    logic [31:0] o, rm; logic oc; int lat, rc; bit aok, sok, eok;
    run_op(2'b10, 32'h0000_0001, T_LSL, 5'd0, 4'h9, 8'd32, 1'b0, 3, 1'b0, 1, o, oc, lat, rc, aok, sok, eok);
    checks++;
    if ({oc, o} !== {1'b1, 32'h0}) begin errors++; $display("FAIL reg_lsl32 got %b/%h exp 1/0", oc, o); end
    checks++;
    if (rc !== 3) begin errors++; $display("FAIL reg_rs_req_cycles got %0d exp 3", rc); end
    checks++;
    if (lat !== 1) begin errors++; $display("FAIL reg_latency got %0d exp 1", lat); end
    checks++;
    if (!aok) begin errors++; $display("FAIL reg_rs_addr got %h exp 9", rs_addr_out); end
    run_op(2'b10, 32'h0000_0001, T_LSL, 5'd0, 4'h2, 8'd33, 1'b1, 1, 1'b0, 0, o, oc, lat, rc, aok, sok, eok);
    checks++;
    if ({oc, o} !== {1'b0, 32'h0}) begin errors++; $display("FAIL reg_lsl33 got %b/%h exp 0/0", oc, o); end
    run_op(2'b10, 32'h8000_0000, T_ASR, 5'd0, 4'h3, 8'd200, 1'b0, 2, 1'b0, 0, o, oc, lat, rc, aok, sok, eok);
    checks++;
    if ({oc, o} !== {1'b1, 32'hFFFF_FFFF}) begin errors++; $display("FAIL reg_asr200 got %b/%h exp 1/ffffffff", oc, o); end
    run_op(2'b10, 32'h8000_0001, T_ROR, 5'd0, 4'h4, 8'd64, 1'b0, 1, 1'b0, 0, o, oc, lat, rc, aok, sok, eok);
    checks++;
    if ({oc, o} !== {1'b1, 32'h8000_0001}) begin errors++; $display("FAIL reg_ror64 got %b/%h exp 1/80000001", oc, o); end
    for (int t = 0; t < 4; t++) begin
      rm = $urandom;
      run_op(2'b10, rm, 2'(t), 5'($urandom), 4'h5, 8'd0, 1'b1, 1, 1'b0, 0, o, oc, lat, rc, aok, sok, eok);
      checks++;
      if ({oc, o} !== {1'b1, rm}) begin errors++; $display("FAIL reg_amt0 type=%0d got %b/%h exp 1/%h", t, oc, o, rm); end
    end
  endtask

  task automatic test_random();
    logic [31:0] o, v; logic oc, c; logic [1:0] m, t; logic [4:0] im; logic [7:0] rs;
    logic [32:0] exp_v; int lat, rc, wn; bit aok, sok, eok;
    for (int i = 0; i < 60; i++) begin
      m = 2'($urandom); v = $urandom; t = 2'($urandom); im = 5'($urandom); c = 1'($urandom);
      case ($urandom_range(0, 5))
        0: rs = 8'd0;
        1: rs = 8'd32;
        2: rs = 8'd33;
        3: rs = 8'd64;
        4: rs = 8'($urandom_range(1, 31));
        default: rs = 8'($urandom);
      endcase
      wn = $urandom_range(1, 3);
      exp_v = model(m, v, t, im, rs, c);
      run_op(m, v, t, im, 4'($urandom), rs, c, wn, 1'b0, $urandom_range(0, 2), o, oc, lat, rc, aok, sok, eok);
      checks++;
      if ({oc, o} !== exp_v) begin
        errors++;
        $display("FAIL rand_result i=%0d mode=%0d type=%0d imm=%0d rs=%0d val=%h c=%b got %b/%h exp %b/%h",
                 i, m, t, im, rs, v, c, oc, o, exp_v[32], exp_v[31:0]);
      end
      checks++;
      if (lat !== 1) begin errors++; $display("FAIL rand_latency i=%0d got %0d exp 1", i, lat); end
      checks++;
      if (rc !== ((m == 2'b10) ? wn : 0)) begin
        errors++; $display("FAIL rand_rs_req i=%0d got %0d exp %0d", i, rc, (m == 2'b10) ? wn : 0);
      end
      checks++;
      if (!aok || !sok || !eok) begin
        errors++; $display("FAIL rand_handshake i=%0d addr=%b stable=%b end=%b exp 1 1 1", i, aok, sok, eok);
      end
    end
  endtask

  task automatic test_backpressure();
    logic [32:0] exp_a, exp_b; logic [31:0] va, vb;
    va = $urandom; vb = $urandom;
    exp_a = model(2'b01, va, T_ROR, 5'd7, 8'd0, 1'b0);
    exp_b = model(2'b01, vb, T_LSL, 5'd3, 8'd0, 1'b1);
    @(posedge clk); #1;
    mode = 2'b01; val = va; typ = T_ROR; imm = 5'd7; c_flag = 1'b0; req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(posedge clk); #1;
    checks++;
    if ({valid, carry, op2} !== {1'b1, exp_a}) begin
      errors++; $display("FAIL bp_first got v=%b %b/%h exp 1 %b/%h", valid, carry, op2, exp_a[32], exp_a[31:0]);
    end
    mode = 2'b01; val = vb; typ = T_LSL; imm = 5'd3; c_flag = 1'b1; req_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      checks++;
      if ({valid, carry, op2, req_ready} !== {1'b1, exp_a, 1'b0}) begin
        errors++; $display("FAIL bp_hold cyc=%0d got v=%b %b/%h rdy=%b exp 1 %b/%h 0",
                           i, valid, carry, op2, req_ready, exp_a[32], exp_a[31:0]);
      end
    end
    ready = 1'b1;
    @(posedge clk); #1;
    ready = 1'b0;
    checks++;
    if ({valid, req_ready} !== 2'b01) begin
      errors++; $display("FAIL bp_release got v=%b rdy=%b exp 0 1", valid, req_ready);
    end
    @(posedge clk); #1;
    req_valid = 1'b0;
    checks++;
    if (req_ready !== 1'b0) begin errors++; $display("FAIL bp_second_accept got rdy=%b exp 0", req_ready); end
    @(posedge clk); #1;
    checks++;
    if ({valid, carry, op2} !== {1'b1, exp_b}) begin
      errors++; $display("FAIL bp_second got v=%b %b/%h exp 1 %b/%h", valid, carry, op2, exp_b[32], exp_b[31:0]);
    end
    ready = 1'b1;
    @(posedge clk); #1;
    ready = 1'b0;
  endtask

  task automatic test_reset_mid();
    bit seen;
    @(posedge clk); #1;
    mode = 2'b10; val = $urandom; typ = T_LSL; rs_addr_in = 4'hA; c_flag = 1'b1; req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (rs_req !== 1'b1) begin errors++; $display("FAIL mid_rs_req_before got %b exp 1", rs_req); end
    rst_n = 1'b0;
    #1;
    checks++;
    if ({rs_req, valid, req_ready, rs_addr_out} !== {1'b0, 1'b0, 1'b1, 4'h0}) begin
      errors++; $display("FAIL mid_reset_async got rs_req=%b v=%b rdy=%b addr=%h exp 0 0 1 0",
                         rs_req, valid, req_ready, rs_addr_out);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    rs_gnt = 1'b1; rs_data = 8'd5;
    @(posedge clk); #1;
    rs_gnt = 1'b0;
    seen = 1'b0;
    repeat (4) begin
      @(posedge clk); #1;
      if (valid || rs_req) seen = 1'b1;
    end
    checks++;
    if (seen || req_ready !== 1'b1) begin
      errors++; $display("FAIL mid_reset_abort got activity=%b rdy=%b exp 0 1", seen, req_ready);
    end
  endtask

`ifdef SHIFT_RS_FORWARD_EN
  task automatic test_forward();
    logic [31:0] o; logic oc; int lat, rc; bit aok, sok, eok;
    run_op(2'b10, 32'h0000_0040, T_LSR, 5'd0, 4'h3, 8'd5, 1'b1, 1, 1'b1, 0, o, oc, lat, rc, aok, sok, eok);
    checks++;
    if ({oc, o} !== {1'b0, 32'h2}) begin errors++; $display("FAIL fwd_result got %b/%h exp 0/2", oc, o); end
    checks++;
    if (rc !== 0 || lat !== 1) begin errors++; $display("FAIL fwd_timing got req=%0d lat=%0d exp 0 1", rc, lat); end
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (2) @(posedge clk);
    #1;
    test_reset();
    rst_n = 1'b1;
    test_imm_rotate();
    test_imm_shift_zero();
    test_reg_shift();
    test_backpressure();
    test_random();
    test_reset_mid();
`ifdef SHIFT_RS_FORWARD_EN
    test_forward();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
